// File: rtl/alu_control_mc.sv
// Multicycle ALU control: decodes {ALUOp, funct} into an ALU operation code and
// sequences 1-bit-per-cycle shifts, stalling the front end via Busy.
module alu_control_mc #(
    parameter int unsigned ALUOP_WIDTH = 3,
    parameter int unsigned FUNCT_WIDTH = 6,
    parameter int unsigned SHAMT_WIDTH = 5,
    parameter int unsigned OP_WIDTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Valid,
    input  logic [ALUOP_WIDTH-1:0] ALUOp,
    input  logic [FUNCT_WIDTH-1:0] ALUFunction,
    input  logic [SHAMT_WIDTH-1:0] Shamt,
    output logic [OP_WIDTH-1:0]    ALUOperation,
    output logic                   ShiftEnable,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Illegal
);

    localparam logic [OP_WIDTH-1:0] OP_AND     = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_OR      = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_NOR     = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_ADD     = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_SUB     = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_LUI     = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SLL     = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRL     = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_ILLEGAL = {OP_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [SHAMT_WIDTH-1:0] count;
    logic [OP_WIDTH-1:0]    dec_op;
    logic                   dec_shift;

    // Operation decode; funct only matters for R-type
    always_comb begin
        dec_op    = OP_ILLEGAL;
        dec_shift = 1'b0;
        case (ALUOp)
            ALUOP_WIDTH'(3'b111): begin
                case (ALUFunction)
                    FUNCT_WIDTH'(6'h20): dec_op = OP_ADD;
                    FUNCT_WIDTH'(6'h22): dec_op = OP_SUB;
                    FUNCT_WIDTH'(6'h24): dec_op = OP_AND;
                    FUNCT_WIDTH'(6'h25): dec_op = OP_OR;
                    FUNCT_WIDTH'(6'h27): dec_op = OP_NOR;
                    FUNCT_WIDTH'(6'h08): dec_op = OP_ADD;
                    FUNCT_WIDTH'(6'h00): begin
                        dec_op    = OP_SLL;
                        dec_shift = 1'b1;
                    end
                    FUNCT_WIDTH'(6'h02): begin
                        dec_op    = OP_SRL;
                        dec_shift = 1'b1;
                    end
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            ALUOP_WIDTH'(3'b000): dec_op = OP_ADD;
            ALUOP_WIDTH'(3'b100): dec_op = OP_SUB;
            ALUOP_WIDTH'(3'b001): dec_op = OP_OR;
            ALUOP_WIDTH'(3'b010): dec_op = OP_AND;
            ALUOP_WIDTH'(3'b011): dec_op = OP_LUI;
            default:              dec_op = OP_ILLEGAL;
        endcase
    end

    // Sequencer; all outputs are registered alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            ALUOperation <= '0;
            ShiftEnable  <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Illegal      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Valid) begin
                        ALUOperation <= dec_op;
                        if (dec_shift && (Shamt != '0)) begin
                            state       <= ST_SHIFT;
                            count       <= Shamt;
                            ShiftEnable <= 1'b1;
                            Busy        <= 1'b1;
                            Done        <= 1'b0;
                            Illegal     <= 1'b0;
                        end else begin
                            state       <= ST_DONE;
                            ShiftEnable <= 1'b0;
                            Busy        <= 1'b0;
                            Done        <= 1'b1;
                            Illegal     <= (dec_op == OP_ILLEGAL);
                        end
                    end else begin
                        state   <= ST_IDLE;
                        Done    <= 1'b0;
                        Illegal <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    count <= count - SHAMT_WIDTH'(1);
                    if (count == SHAMT_WIDTH'(1)) begin
                        state       <= ST_DONE;
                        ShiftEnable <= 1'b0;
                        Busy        <= 1'b0;
                        Done        <= 1'b1;
                        Illegal     <= (ALUOperation == OP_ILLEGAL);
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    ShiftEnable <= 1'b0;
                    Busy        <= 1'b0;
                    Done        <= 1'b0;
                    Illegal     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_mc.sv
// Bench for alu_control_mc: transaction-level timing model checked every cycle,
// plus directed vectors with literal expectations.
module tb_alu_control_mc;

    localparam int unsigned AW = 3;
    localparam int unsigned FW = 6;
    localparam int unsigned SW = 5;
    localparam int unsigned OW = 4;
    localparam int ILL = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          Valid = 1'b0;
    logic [AW-1:0] ALUOp = '0;
    logic [FW-1:0] ALUFunction = '0;
    logic [SW-1:0] Shamt = '0;
    logic [OW-1:0] ALUOperation;
    logic          ShiftEnable;
    logic          Busy;
    logic          Done;
    logic          Illegal;

    always #5 clk = ~clk;

    alu_control_mc #(
        .ALUOP_WIDTH(AW), .FUNCT_WIDTH(FW), .SHAMT_WIDTH(SW), .OP_WIDTH(OW)
    ) dut (
        .clk(clk), .reset(reset), .Valid(Valid), .ALUOp(ALUOp),
        .ALUFunction(ALUFunction), .Shamt(Shamt), .ALUOperation(ALUOperation),
        .ShiftEnable(ShiftEnable), .Busy(Busy), .Done(Done), .Illegal(Illegal)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int se_total = 0;
    bit run = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Operation table straight from the instruction set definition
    function automatic int decode(input int aluop, input int funct);
        if (aluop == 7) begin
            case (funct)
                'h20: return 3;
                'h22: return 4;
                'h24: return 0;
                'h25: return 1;
                'h27: return 2;
                'h00: return 6;
                'h02: return 7;
                'h08: return 3;
                default: return ILL;
            endcase
        end
        case (aluop)
            0: return 3;
            4: return 4;
            1: return 1;
            2: return 0;
            3: return 5;
            default: return ILL;
        endcase
    endfunction

    // Timing model: a request accepted at edge a with n shift steps keeps the
    // unit busy for cycles a..a+n-1, signals done in cycle a+n, and the next
    // request can be sampled from edge a+n+1 on.
    int edge_i  = 0;
    int acc     = -1000;
    int nsh     = 0;
    int free_at = 0;
    int m_op    = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_i  = 0;
            acc     = -1000;
            nsh     = 0;
            free_at = 0;
            m_op    = 0;
        end else begin
            edge_i++;
            if (edge_i >= free_at && Valid) begin
                m_op    = decode(int'(ALUOp), int'(ALUFunction));
                nsh     = (m_op == 6 || m_op == 7) ? int'(Shamt) : 0;
                acc     = edge_i;
                free_at = acc + nsh + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            int eb;
            int ed;
            eb = (edge_i >= acc && edge_i < acc + nsh) ? 1 : 0;
            ed = (edge_i == acc + nsh) ? 1 : 0;
            chk("model.op", int'(ALUOperation), m_op);
            chk("model.shift_en", int'(ShiftEnable), eb);
            chk("model.busy", int'(Busy), eb);
            chk("model.done", int'(Done), ed);
            chk("model.illegal", int'(Illegal), (ed == 1 && m_op == ILL) ? 1 : 0);
            se_total += int'(ShiftEnable);
        end
    end

    task automatic step(input bit v, input int op, input int f, input int s);
        Valid       = v;
        ALUOp       = AW'(op);
        ALUFunction = FW'(f);
        Shamt       = SW'(s);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string n, input int op, input int se, input int busy,
                       input int done, input int ill);
        chk({n, ".op"}, int'(ALUOperation), op);
        chk({n, ".shift_en"}, int'(ShiftEnable), se);
        chk({n, ".busy"}, int'(Busy), busy);
        chk({n, ".done"}, int'(Done), done);
        chk({n, ".illegal"}, int'(Illegal), ill);
    endtask

    typedef struct {
        int aluop;
        int funct;
        int shamt;
        int exp_op;
    } vec_t;

    vec_t vecs[11] = '{
        '{7, 'h20, 0, 3}, '{7, 'h24, 0, 0}, '{7, 'h25, 0, 1}, '{7, 'h27, 0, 2},
        '{7, 'h08, 0, 3}, '{0, 'h22, 7, 3}, '{4, 'h00, 0, 4}, '{1, 'h00, 0, 1},
        '{2, 'h02, 3, 0}, '{3, 'h00, 9, 5}, '{5, 'h20, 0, 15}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        run = 1'b1;
        #1;
        lit("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;

        // single-cycle SUB
        step(1, 7, 'h22, 0); lit("sub", 4, 0, 0, 1, 0);
        step(0, 0, 0, 0);    lit("sub_idle", 4, 0, 0, 0, 0);

        // SLL by 3
        step(1, 7, 'h00, 3); lit("sll3_1", 6, 1, 1, 0, 0);
        step(0, 0, 0, 0);    lit("sll3_2", 6, 1, 1, 0, 0);
        step(0, 0, 0, 0);    lit("sll3_3", 6, 1, 1, 0, 0);
        step(0, 0, 0, 0);    lit("sll3_done", 6, 0, 0, 1, 0);
        step(0, 0, 0, 0);    lit("sll3_idle", 6, 0, 0, 0, 0);

        // SRL by 0, then by the maximum
        s0 = se_total;
        step(1, 7, 'h02, 0); lit("srl0", 7, 0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("srl0.shift_cycles", se_total - s0, 0);
        s0 = se_total;
        step(1, 7, 'h02, 31); lit("srl31_first", 7, 1, 1, 0, 0);
        repeat (30) step(0, 0, 0, 0);
        lit("srl31_last", 7, 1, 1, 0, 0);
        step(0, 0, 0, 0);    lit("srl31_done", 7, 0, 0, 1, 0);
        chk("srl31.shift_cycles", se_total - s0, 31);
        step(0, 0, 0, 0);

        // illegal codes, back to back
        step(1, 7, 'h3F, 0); lit("ill_funct", 15, 0, 0, 1, 1);
        step(1, 6, 'h20, 0); lit("ill_aluop", 15, 0, 0, 1, 1);
        step(0, 0, 0, 0);    lit("ill_idle", 15, 0, 0, 0, 0);

        // Valid held: ori, SLL accepted from DONE, mid-shift requests dropped
        step(1, 1, 0, 0);    lit("ori", 1, 0, 0, 1, 0);
        step(1, 7, 'h00, 2); lit("b2b_sll_1", 6, 1, 1, 0, 0);
        step(1, 0, 0, 0);    lit("b2b_sll_2", 6, 1, 1, 0, 0);
        step(1, 4, 0, 0);    lit("b2b_sll_done", 6, 0, 0, 1, 0);
        step(0, 0, 0, 0);    lit("b2b_idle", 6, 0, 0, 0, 0);

        // decode table
        foreach (vecs[i]) begin
            step(1, vecs[i].aluop, vecs[i].funct, vecs[i].shamt);
            lit($sformatf("dec%0d", i), vecs[i].exp_op, 0, 0, 1,
                (vecs[i].exp_op == ILL) ? 1 : 0);
            step(0, 0, 0, 0);
        end

        // asynchronous reset in the middle of a shift
        step(1, 7, 'h00, 5); lit("rst_sll_1", 6, 1, 1, 0, 0);
        step(0, 0, 0, 0);    lit("rst_sll_2", 6, 1, 1, 0, 0);
        #2 reset = 1'b0;
        #1 lit("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        lit("rst_hold", 0, 0, 0, 0, 0);
        step(1, 0, 0, 0);    lit("post_rst_add", 3, 0, 0, 1, 0);
        step(0, 0, 0, 0);    lit("post_rst_idle", 3, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
- Multicycle successor to the single-cycle ALU control decoder.
- Decodes {ALUOp, ALUFunction} into a parametrised ALU operation code.
- Sequences iterative shift operations (SLL/SRL) over Shamt cycles, driving a 1-bit-per-cycle shifter in the datapath.
- Sits between the main control unit and the ALU/shifter. Busy stalls the PC/pipeline front end while a shift is in flight.

Parameters:
- ALUOP_WIDTH, 3: width of ALUOp from the main control unit.
- FUNCT_WIDTH, 6: width of the instruction funct field.
- SHAMT_WIDTH, 5: width of the shift amount. Maximum shift count is 2^SHAMT_WIDTH-1.
- OP_WIDTH, 4: width of ALUOperation. Must be ≥4. ILLEGAL code is all ones.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Valid  in  1  request; sampled on the rising edge only when Busy=0.
- ALUOp  in  ALUOP_WIDTH  operation class from the main control unit.
- ALUFunction  in  FUNCT_WIDTH  instruction funct field.
- Shamt  in  SHAMT_WIDTH  shift amount.
- ALUOperation  out  OP_WIDTH  registered ALU operation code.
- ShiftEnable  out  1  high for exactly one cycle per 1-bit shift step.
- Busy  out  1  operation in progress; new requests are not accepted.
- Done  out  1  one-cycle pulse when an operation completes.
- Illegal  out  1  pulses with Done when the accepted code is unsupported.

Behaviour:
- Operation codes (zero-extended to OP_WIDTH): AND=0, OR=1, NOR=2, ADD=3, SUB=4, LUI=5, SLL=6, SRL=7, ILLEGAL=all ones.
- ALUOp decode:
  - 3'b111: R-type, decoded by funct.
  - 3'b000: ADD (addi/lw/sw/jal).
  - 3'b100: SUB (beq/bne).
  - 3'b001: OR (ori).
  - 3'b010: AND (andi).
  - 3'b011: LUI.
  - All other ALUOp values: ILLEGAL.
- R-type funct decode:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR.
  - 0x00 SLL, 0x02 SRL.
  - 0x08 (jr) → ADD.
  - Other funct values: ILLEGAL.
  - When ALUOp≠3'b111, funct and Shamt are ignored.
- State machine: IDLE, SHIFT, DONE. Internal down-counter is SHAMT_WIDTH bits.
- Accept condition: Valid=1 while in IDLE or DONE. ALUOperation is loaded with the decoded code on the accepting edge.
  - Non-shift op, or shift with Shamt=0 → DONE. Done=1 the cycle after acceptance (latency 1). ShiftEnable stays 0.
  - Shift with Shamt=N>0 → SHIFT, counter=N.
- SHIFT state:
  - Busy=1, ShiftEnable=1; counter decrements each cycle.
  - On the cycle counter=1 → DONE.
  - ShiftEnable is high for exactly N consecutive cycles, starting the cycle after acceptance.
  - Done asserts N+1 cycles after acceptance.
- DONE state:
  - Done=1, Busy=0; Illegal=1 iff ALUOperation=ILLEGAL.
  - With Valid=1 → accept back-to-back (no bubble). Otherwise → IDLE.
- Valid while Busy=1 is ignored; the request is not queued. Inputs change freely during SHIFT with no effect.
- ALUOperation holds its value until the next accepted request.
- Busy, ShiftEnable, Done and Illegal are all registered/state-decoded outputs; no combinational path from inputs.
- Reset (asynchronous, any time including mid-shift):
  - State=IDLE, counter=0.
  - ALUOperation=0, ShiftEnable=0, Busy=0, Done=0, Illegal=0.
  - Shift is abandoned, with no Done pulse.
- Max shift: Shamt=all ones gives ShiftEnable for 2^SHAMT_WIDTH-1 cycles; counter does not wrap.

Test Plan:
- Reset then Valid with ALUOp=3'b111, funct=0x22 → next cycle ALUOperation=4, Done=1, Busy=0, ShiftEnable=0. Illegal=0.
- Valid with ALUOp=3'b111, funct=0x00, Shamt=3 → Busy=1 and ShiftEnable=1 for cycles +1..+3, ALUOperation=6. Done=1 at +4 only.
- SRL with Shamt=0 → Done at +1, ShiftEnable never asserted, ALUOperation=7. Then Shamt=31 gives exactly 31 ShiftEnable cycles and Done at +32.
- ALUOp=3'b111, funct=0x3F, then ALUOp=3'b110 → ALUOperation=4'hF, Done=1 and Illegal=1 for one cycle each.
- Valid held high: ori, then SLL Shamt=2 during DONE, then Valid pulses during SHIFT → ori Done at +1. SLL accepted in that DONE cycle, completes at +4. Mid-shift requests are ignored.
- Assert reset low at the second ShiftEnable cycle of an SLL Shamt=5 → all outputs 0 immediately (asynchronously). No Done pulse. After release, the next Valid(ADD) gives Done at +1.
